// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage MIPS core.
// Captures decode control/operands each cycle for EX and detects load-use
// hazards against the load currently in EX.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 branch taken in EX; kill the ID instruction
//   id_*                  decode-stage control, specifiers and operands
//   stall                 combinational; hold PC and IF/ID this cycle
//   ex_valid              EX holds a real instruction
//   ex_*                  registered copies of the id_* inputs (zero on bubble)
//   bubble_count          saturating count of inserted bubbles
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic [4:0]        id_shamt,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_branch,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  output logic              stall,
  output logic              ex_valid,
  output logic [1:0]        ex_alu_op,
  output logic [5:0]        ex_funct,
  output logic [4:0]        ex_shamt,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic              ex_branch,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic              valid;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic              reg_dst;
    logic              branch;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
  } ex_t;

  ex_t              ex_d, ex_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             hazard;

  always_comb begin
    // $0 is hard-wired zero, so a load targeting it creates no dependency.
    hazard = ex_q.mem_read & ex_q.valid & (ex_q.rt != 5'd0) &
             ((id_uses_rs & (id_rs == ex_q.rt)) |
              (id_uses_rt & (id_rt == ex_q.rt)));
    // A flushed ID instruction is discarded, so fetch must keep moving.
    stall = hazard & ~flush & ~reset;

    ex_d  = '0;
    cnt_d = cnt_q;
    if (flush || hazard) begin
      // All-zero bubble: ALUOp add, no writes, no memory access.
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else begin
      ex_d.valid      = 1'b1;
      ex_d.alu_op     = id_alu_op;
      ex_d.funct      = id_funct;
      ex_d.shamt      = id_shamt;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.rd         = id_rd;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.alu_src    = id_alu_src;
      ex_d.reg_dst    = id_reg_dst;
      ex_d.branch     = id_branch;
      ex_d.rdata1     = id_rdata1;
      ex_d.rdata2     = id_rdata2;
      ex_d.imm        = id_imm;
      ex_d.pc4        = id_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_funct      = ex_q.funct;
  assign ex_shamt      = ex_q.shamt;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_branch     = ex_q.branch;
  assign ex_rdata1     = ex_q.rdata1;
  assign ex_rdata2     = ex_q.rdata2;
  assign ex_imm        = ex_q.imm;
  assign ex_pc4        = ex_q.pc4;
  assign bubble_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (bubble counter narrowed to 2 bits so
// saturation is reachable).
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, flush;
  logic [1:0]        id_alu_op;
  logic [5:0]        id_funct;
  logic [4:0]        id_shamt, id_rs, id_rt, id_rd;
  logic              id_uses_rs, id_uses_rt;
  logic              id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
  logic              id_alu_src, id_reg_dst, id_branch;
  logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
  logic              stall, ex_valid;
  logic [1:0]        ex_alu_op;
  logic [5:0]        ex_funct;
  logic [4:0]        ex_shamt, ex_rs, ex_rt, ex_rd;
  logic              ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic              ex_alu_src, ex_reg_dst, ex_branch;
  logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic [CNT_W-1:0]  bubble_count;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_shamt(id_shamt),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_branch(id_branch),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
    .stall(stall), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .ex_funct(ex_funct), .ex_shamt(ex_shamt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_alu_op = 0; id_funct = 0; id_shamt = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_reg_write = 0; id_mem_to_reg = 0;
    id_mem_read = 0; id_mem_write = 0; id_alu_src = 0; id_reg_dst = 0;
    id_branch = 0; id_rdata1 = 0; id_rdata2 = 0; id_imm = 0; id_pc4 = 0;
  endtask

  // lw $rt, imm($rs)
  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
    clr_id();
    id_rs = rs; id_rt = rt; id_uses_rs = 1; id_mem_read = 1; id_reg_write = 1;
    id_mem_to_reg = 1; id_alu_src = 1; id_imm = 32'h4; id_pc4 = 32'h100;
  endtask

  initial begin
    reset = 1; flush = 0;
    clr_id();
    // arbitrary decode content while in reset
    id_alu_op = 2; id_funct = 6'h2a; id_rs = 5; id_rt = 5; id_uses_rs = 1;
    id_reg_write = 1; id_mem_read = 1; id_rdata1 = 32'hdead_beef; id_pc4 = 32'h44;
    tick();
    tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_alu_op", ex_alu_op, 0);
    chk("rst_funct", ex_funct, 0);
    chk("rst_rdata1", ex_rdata1, 0);
    chk("rst_reg_write", ex_reg_write, 0);
    chk("rst_mem_read", ex_mem_read, 0);
    chk("rst_stall", stall, 0);
    chk("rst_bubbles", bubble_count, 0);

    // pass-through of an R-type sub
    reset = 0;
    clr_id();
    id_alu_op = 2; id_funct = 34; id_rdata1 = 32'h10; id_rdata2 = 32'h3;
    id_reg_write = 1; id_rs = 1; id_rt = 2; id_rd = 3; id_uses_rs = 1; id_uses_rt = 1;
    id_shamt = 5'd9; id_reg_dst = 1; id_pc4 = 32'h204; id_imm = 32'hffff_fff0;
    #1 chk("pt_stall", stall, 0);
    tick();
    chk("pt_alu_op", ex_alu_op, 2);
    chk("pt_funct", ex_funct, 34);
    chk("pt_rdata1", ex_rdata1, 32'h10);
    chk("pt_rdata2", ex_rdata2, 32'h3);
    chk("pt_reg_write", ex_reg_write, 1);
    chk("pt_valid", ex_valid, 1);
    chk("pt_rd", ex_rd, 3);
    chk("pt_shamt", ex_shamt, 9);
    chk("pt_reg_dst", ex_reg_dst, 1);
    chk("pt_pc4", ex_pc4, 32'h204);
    chk("pt_imm", ex_imm, 32'hffff_fff0);

    // load-use: lw $5 then add $7,$5,$6
    drive_lw(2, 5);
    #1 chk("lu_pre_stall", stall, 0);
    tick();
    chk("lu_lw_mem_read", ex_mem_read, 1);
    chk("lu_lw_rt", ex_rt, 5);
    clr_id();
    id_alu_op = 2; id_funct = 32; id_rs = 5; id_rt = 6; id_rd = 7;
    id_uses_rs = 1; id_uses_rt = 1; id_reg_write = 1; id_reg_dst = 1;
    id_rdata1 = 32'h55; id_rdata2 = 32'h66;
    #1 chk("lu_stall", stall, 1);
    tick();
    chk("lu_bub_valid", ex_valid, 0);
    chk("lu_bub_reg_write", ex_reg_write, 0);
    chk("lu_bub_mem_read", ex_mem_read, 0);
    chk("lu_bub_rt", ex_rt, 0);
    chk("lu_bub_count", bubble_count, 1);
    chk("lu_stall_done", stall, 0);
    tick();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rd", ex_rd, 7);
    chk("lu_add_funct", ex_funct, 32);
    chk("lu_add_rdata1", ex_rdata1, 32'h55);
    chk("lu_add_count", bubble_count, 1);

    // load into $0 never stalls
    drive_lw(1, 0);
    tick();
    clr_id();
    id_rs = 0; id_uses_rs = 1; id_rt = 0; id_uses_rt = 1;
    #1 chk("zero_stall", stall, 0);

    // unused rt operand does not stall; used rt does
    drive_lw(1, 7);
    tick();
    clr_id();
    id_rs = 3; id_uses_rs = 1; id_rt = 7; id_uses_rt = 0;
    #1 chk("unused_rt_stall", stall, 0);
    id_uses_rt = 1;
    #1 chk("used_rt_stall", stall, 1);

    // flush beats hazard: no stall, one bubble counted
    flush = 1;
    #1 chk("flush_stall", stall, 0);
    tick();
    flush = 0;
    chk("flush_bub_valid", ex_valid, 0);
    chk("flush_bub_mem_read", ex_mem_read, 0);
    chk("flush_count", bubble_count, 2);

    // reset during a stall: stall drops immediately, state clears
    drive_lw(1, 9);
    tick();
    clr_id();
    id_rs = 9; id_uses_rs = 1;
    #1 chk("rs_stall_on", stall, 1);
    reset = 1;
    #1 chk("rs_stall_off", stall, 0);
    tick();
    chk("rs_valid", ex_valid, 0);
    chk("rs_count", bubble_count, 0);
    reset = 0;

    // saturation with 2-bit counter: 1,2,3,3,3
    clr_id();
    flush = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sat_%0d", i), bubble_count, (i < 3) ? i + 1 : 3);
    end
    flush = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage pipelined MIPS core, with load-use hazard detection built in.
- Captures decode-stage control and operands every cycle and presents them to EX.
- Its ex_alu_op and ex_funct outputs drive the ALU control decoder directly.
- On a load-use hazard it stalls PC and IF/ID for one cycle and inserts a bubble. On a branch flush it inserts a bubble. It also keeps a saturating count of inserted bubbles.

Parameters:
- DATA_W, 32, width of register operands, immediate and PC+4.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  branch taken in EX; kill the instruction currently in ID.
- id_alu_op  input  2  decode ALUOp (0 add, 1 sub, 2 R-type).
- id_funct  input  6  instr[5:0].
- id_shamt  input  5  instr[10:6].
- id_rs, id_rt, id_rd  input  5 each  register specifiers.
- id_uses_rs, id_uses_rt  input  1 each  instruction in ID reads that register.
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_branch  input  1 each  decode control bits.
- id_rdata1, id_rdata2, id_imm, id_pc4  input  DATA_W each  register file reads, sign-extended immediate, PC+4.
- stall  output  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  output  1  EX holds a real instruction.
- ex_alu_op, ex_funct, ex_shamt, ex_rs, ex_rt, ex_rd  output  registered copies of the matching inputs.
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst, ex_branch  output  1 each  registered control.
- ex_rdata1, ex_rdata2, ex_imm, ex_pc4  output  DATA_W each  registered operands.
- bubble_count  output  CNT_W  bubbles inserted since reset.

Behaviour:
- Hazard detection (combinational):
  - hazard = ex_mem_read & ex_valid & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
  - stall = hazard & ~flush & ~reset.
- Register update priority each rising edge, highest first:
  1. reset: all ex_* outputs cleared to 0 (ex_alu_op=0, ex_funct=0, ex_valid=0, all operands 0); bubble_count=0.
  2. flush: bubble; bubble_count increments.
  3. hazard: bubble; bubble_count increments.
  4. otherwise: capture every id_* input into the matching ex_* output; ex_valid=1.
- Bubble: every ex_* output loaded with 0, including operands and specifiers, so EX sees ALUOp 0 (add) with no side effects; ex_valid=0.
- Latency: one cycle from the id_* inputs to the ex_* outputs.
- Stall duration: a load-use stall lasts exactly one cycle. The bubble clears ex_mem_read, so hazard deasserts the next cycle and the held instruction then enters EX.
- flush and hazard in the same cycle: flush wins and stall=0. The ID instruction is discarded, so fetch must not be held.
- Register $0 never causes a hazard.
- A hazard requires ex_valid=1.
- bubble_count saturates at all-ones and does not wrap.
- Reset asserted mid-stall: the next edge clears the register, and stall=0 while reset is high.
- No other state exists; there is no FSM beyond the ex_valid/bubble decision.

Test Plan:
- Reset: hold reset 2 cycles with arbitrary id_* inputs -> all ex_* outputs 0, stall=0, bubble_count=0.
- Pass-through: id_alu_op=2, id_funct=34, id_rdata1=0x10, id_rdata2=0x3, id_reg_write=1, no hazard -> next cycle ex_alu_op=2, ex_funct=34, ex_rdata1=0x10, ex_rdata2=0x3, ex_reg_write=1, ex_valid=1.
- Load-use: lw $5 sits in EX (ex_mem_read=1, ex_rt=5, ex_valid=1); ID holds add reading rs=5 with id_uses_rs=1 -> stall=1 for exactly one cycle; next EX content is a bubble (ex_valid=0, ex_reg_write=0); the cycle after, the add appears in EX; bubble_count=1.
- $0 / unused operand: ex_rt=0 with ex_mem_read=1, id_rs=0 -> stall=0. Separately, ex_rt=7 with id_rt=7 but id_uses_rt=0 -> stall=0.
- Flush priority: hazard condition true and flush=1 in the same cycle -> stall=0; next cycle bubble in EX; bubble_count increments by 1, not 2.
- Saturation: with CNT_W=2, force 5 consecutive flush cycles -> bubble_count reads 1, 2, 3, 3, 3.
